ntt_butterfly_engine: RTL and testbench
=======================================

Name: ntt_butterfly_engine

Overview:
- Iterative 8-point NTT engine over Z_Q. It sits directly upstream of the transform-result buffer.
- Accepts one row of eight 8-bit coefficients and runs a radix-2 decimation-in-time transform, one butterfly per clock.
- Presents the eight results, plus a write strobe and a row index, for the buffer to capture as one stored row.

Parameters:
- Q, 17, prime modulus; 2 <= Q <= 251; Q mod 8 == 1.
- W_DATA, 8, coefficient width in bits; fixed at 8.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input row offered
- in_ready  out  1  engine can accept a row
- a  in  8x8  input coefficients a[0..7]
- tw  in  4x8  twiddles tw[k] = omega^k mod Q, k=0..3; sampled at acceptance
- out_valid  out  1  result row valid
- out_ready  in  1  downstream takes the result
- c  out  8x8  transform result c[0..7], natural order
- wr_pulse  out  1  one-cycle strobe = out_valid & out_ready (buffer write enable)
- row_idx  out  4  count of completed rows, wraps 15->0
- busy  out  1  high in COMPUTE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; in_ready=1; out_valid=0; busy=0; row_idx=0; c=0.
  - Work registers and latched twiddles are cleared.
  - Reset mid-COMPUTE or mid-DONE abandons the row silently; no wr_pulse is issued.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready:
    - load x[bitrev3(i)] = a[i] mod Q;
    - latch tw[0..3];
    - stage=0, bfly=0; go to COMPUTE.
  - COMPUTE: in_ready=0, busy=1. Each cycle performs one butterfly (12 total: 3 stages x 4).
    - half = 1<<stage.
    - j = bfly & (half-1).
    - top = (bfly>>stage)*2*half + j.
    - bot = top + half.
    - twiddle = tw[j*(4>>stage)].
    - t = (twiddle*x[bot]) mod Q; 16-bit product, then reduced.
    - x[top] = (x[top]+t) mod Q.
    - x[bot] = (x[top]-t+Q) mod Q, using the pre-update x[top].
    - bfly increments 0..3, then wraps and stage increments. After stage 2, bfly 3: copy x to c, out_valid=1, go to DONE.
  - DONE: out_valid=1; c and out_valid are held stable until out_ready.
    - On out_valid&out_ready: wr_pulse=1 that cycle; row_idx+1 at the edge; out_valid=0; back to IDLE, in_ready=1 next cycle.
    - No new row is accepted in DONE. Throughput is 1 row per 14 cycles minimum.
- Latency: acceptance edge E0; butterflies on edges E1..E12; out_valid high after E12.
- Arithmetic:
  - All stored values are < Q at all times.
  - Twiddles >= Q are reduced mod Q on latch.
  - Subtraction never underflows; Q is added before the reduction.
- Output properties:
  - c is registered and changes only on entry to DONE.
  - c is held after leaving DONE until the next completion.
  - wr_pulse is combinational from registered out_valid and the input out_ready.
- Input rules:
  - in_valid while in_ready=0 is ignored; upstream must hold a until accepted.
  - out_ready while out_valid=0 has no effect.

Test Plan:
- Impulse: Q=17, tw={1,2,4,8}, a={1,0,0,0,0,0,0,0} -> c={1,1,1,1,1,1,1,1}; out_valid rises 12 cycles after the acceptance edge; wr_pulse lasts one cycle; row_idx=1.
- Shifted impulse: a={0,1,0,0,0,0,0,0} -> c={1,2,4,8,16,15,13,9}.
- DC row: a all 1 -> c={8,0,0,0,0,0,0,0}. Input reduction: a={18,0,...} -> same result as the impulse test (all 1).
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> c and out_valid stable, in_ready=0, new in_valid ignored, no wr_pulse. Release -> single wr_pulse, then in_ready=1.
- Reset mid-operation: assert rst_n=0 at butterfly 6 -> immediate in_ready=1, out_valid=0, row_idx=0. The next impulse row yields correct all-ones output.
- Wrap and back-to-back: 17 consecutive rows with out_ready=1 -> 17 wr_pulses, row_idx ends at 1. Each row's c matches a software NTT reference.

Source files
------------

// File: rtl/ntt_butterfly_engine.sv
// ntt_butterfly_engine
//   Iterative 8-point radix-2 decimation-in-time NTT over Z_Q, one butterfly
//   per clock. A row is loaded in bit-reversed order, transformed in place over
//   3 stages x 4 butterflies, and presented in natural order to the
//   downstream transform-result buffer.
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   input row handshake; a[0..7] and tw[0..3] sampled on accept
//   a                   eight input coefficients (reduced mod Q on load)
//   tw                  twiddles omega^k mod Q, k=0..3 (reduced mod Q on latch)
//   out_valid/out_ready result handshake
//   c                   registered transform result, natural order
//   wr_pulse            buffer write enable = out_valid & out_ready
//   row_idx             completed-row counter, wraps 15->0
//   busy                high while butterflies are being computed
module ntt_butterfly_engine #(
  parameter int unsigned Q      = 17,
  parameter int unsigned W_DATA = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0][W_DATA-1:0] a,
  input  logic [3:0][W_DATA-1:0] tw,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0][W_DATA-1:0] c,
  output logic                   wr_pulse,
  output logic [3:0]             row_idx,
  output logic                   busy
);

  typedef logic [W_DATA-1:0] coef_t;
  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  localparam coef_t QW = coef_t'(Q);

  state_t                   state, state_nxt;
  logic   [1:0]             stage, bfly;
  logic   [7:0][W_DATA-1:0] x, x_upd;
  logic   [3:0][W_DATA-1:0] twr;

  logic   [2:0]             bfly3, half, j, top, bot;
  logic   [1:0]             tw_idx;
  logic   [15:0]            prod;
  coef_t                    t;
  logic   [8:0]             sum, diff;

  logic accept, last_bfly;

  function automatic logic [2:0] bitrev3(input logic [2:0] i);
    return {i[0], i[1], i[2]};
  endfunction

  assign in_ready  = (state == IDLE);
  assign busy      = (state == COMPUTE);
  assign out_valid = (state == DONE);
  assign wr_pulse  = out_valid & out_ready;
  assign accept    = in_valid & in_ready;
  assign last_bfly = (stage == 2'd2) && (bfly == 2'd3);

  // Butterfly addressing: the span doubles each stage; twiddle stride halves.
  always_comb begin
    bfly3  = {1'b0, bfly};
    half   = 3'd1 << stage;
    j      = bfly3 & (half - 3'd1);
    top    = ((bfly3 >> stage) << (stage + 2'd1)) + j;
    bot    = top + half;
    tw_idx = 2'(j << (2'd2 - stage));
    prod   = 16'(twr[tw_idx]) * 16'(x[bot]);
    t      = coef_t'(prod % 16'(Q));
    sum    = 9'(x[top]) + 9'(t);
    // Q is added before subtracting so the difference never wraps.
    diff   = 9'(x[top]) + 9'(Q) - 9'(t);
    x_upd      = x;
    x_upd[top] = coef_t'(sum % 9'(Q));
    x_upd[bot] = coef_t'(diff % 9'(Q));
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = COMPUTE;
      COMPUTE: if (last_bfly) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage   <= '0;
      bfly    <= '0;
      x       <= '0;
      twr     <= '0;
      c       <= '0;
      row_idx <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            for (int unsigned i = 0; i < 8; i++)
              x[bitrev3(3'(i))] <= coef_t'(a[i] % QW);
            for (int unsigned k = 0; k < 4; k++)
              twr[k] <= coef_t'(tw[k] % QW);
            stage <= '0;
            bfly  <= '0;
          end
        end
        COMPUTE: begin
          x    <= x_upd;
          bfly <= bfly + 2'd1;
          if (bfly == 2'd3) stage <= stage + 2'd1;
          if (last_bfly) c <= x_upd;
        end
        DONE: begin
          if (out_ready) row_idx <= row_idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_butterfly_engine.sv
module tb_ntt_butterfly_engine;
  localparam int unsigned Q = 17;

  logic            clk = 1'b0;
  logic            rst_n, in_valid, in_ready, out_valid, out_ready, wr_pulse, busy;
  logic [7:0][7:0] a, c;
  logic [3:0][7:0] tw;
  logic [3:0]      row_idx;

  int compared   = 0;
  int mismatched = 0;
  int wr_count   = 0;
  int exp_row    = 0;

  int unsigned ain[8];
  int unsigned twin[4];
  int unsigned expc[8];
  int unsigned omega;
  int unsigned roots[4] = '{2, 8, 9, 15};  // elements of order 8 mod 17

  ntt_butterfly_engine #(.Q(Q), .W_DATA(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .tw(tw), .out_valid(out_valid), .out_ready(out_ready), .c(c),
    .wr_pulse(wr_pulse), .row_idx(row_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wr_pulse === 1'b1) wr_count++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned powmod(input int unsigned b, input int unsigned e);
    int unsigned r = 1;
    for (int unsigned i = 0; i < e; i++) r = (r * b) % Q;
    return r;
  endfunction

  // Direct DFT over Z_Q: c[k] = sum a[i] * omega^(i*k).
  function automatic void model();
    for (int k = 0; k < 8; k++) begin
      int unsigned s = 0;
      for (int i = 0; i < 8; i++)
        s += (ain[i] % Q) * powmod(omega, (i * k) % 8);
      expc[k] = s % Q;
    end
  endfunction

  function automatic void set_tw(input int unsigned om, input bit add_q);
    omega = om;
    for (int k = 0; k < 4; k++)
      twin[k] = powmod(om, k) + ((add_q && $urandom_range(0, 1) == 1) ? Q : 0);
  endfunction

  task automatic drive_row();
    int n = 0;
    for (int i = 0; i < 8; i++) a[i] = 8'(ain[i]);
    for (int k = 0; k < 4; k++) tw[k] = 8'(twin[k]);
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 100) begin step(); n++; end
    if (n >= 100) check("accept_timeout", 0, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin step(); lat++; end
    check("done_reached", 64'(out_valid), 1);
  endtask

  task automatic check_c(input string tag);
    for (int k = 0; k < 8; k++)
      check($sformatf("%s c[%0d]", tag, k), 64'(c[k]), 64'(expc[k]));
  endtask

  task automatic handshake(input string tag);
    int w0 = wr_count;
    out_ready = 1'b1;
    #1;
    check({tag, " wr_pulse_hi"}, 64'(wr_pulse), 1);
    step();
    out_ready = 1'b0;
    #1;
    check({tag, " wr_pulse_lo"}, 64'(wr_pulse), 0);
    check({tag, " in_ready"}, 64'(in_ready), 1);
    check({tag, " out_valid"}, 64'(out_valid), 0);
    exp_row = (exp_row + 1) % 16;
    check({tag, " row_idx"}, 64'(row_idx), 64'(exp_row));
    check({tag, " one_pulse"}, 64'(wr_count - w0), 1);
  endtask

  initial begin
    int lat;
    int w0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; tw = '0;
    #12;
    check("rst in_ready", 64'(in_ready), 1);
    check("rst out_valid", 64'(out_valid), 0);
    check("rst busy", 64'(busy), 0);
    check("rst row_idx", 64'(row_idx), 0);
    check("rst c", 64'(c), 0);
    rst_n = 1'b1;
    step();

    // Impulse
    ain = '{1, 0, 0, 0, 0, 0, 0, 0};
    set_tw(2, 1'b0);
    drive_row();
    check("imp busy", 64'(busy), 1);
    check("imp in_ready", 64'(in_ready), 0);
    wait_done(lat);
    check("imp latency", 64'(lat), 12);
    expc = '{1, 1, 1, 1, 1, 1, 1, 1};
    check_c("imp");
    handshake("imp");

    // Shifted impulse, fixed expectation then the model cross-check
    ain = '{0, 1, 0, 0, 0, 0, 0, 0};
    drive_row();
    wait_done(lat);
    expc = '{1, 2, 4, 8, 16, 15, 13, 9};
    check_c("shift");
    model();
    check_c("shift_model");
    handshake("shift");

    // DC row
    ain = '{1, 1, 1, 1, 1, 1, 1, 1};
    drive_row();
    wait_done(lat);
    expc = '{8, 0, 0, 0, 0, 0, 0, 0};
    check_c("dc");
    handshake("dc");

    // Input reduction: 18 mod 17 = 1, twiddles offset by Q
    ain = '{18, 0, 0, 0, 0, 0, 0, 0};
    twin = '{18, 19, 21, 25};
    drive_row();
    wait_done(lat);
    expc = '{1, 1, 1, 1, 1, 1, 1, 1};
    check_c("reduce");
    handshake("reduce");

    // Backpressure in DONE
    for (int i = 0; i < 8; i++) ain[i] = $urandom_range(0, 255);
    set_tw(roots[$urandom_range(0, 3)], 1'b1);
    model();
    drive_row();
    wait_done(lat);
    w0 = wr_count;
    for (int i = 0; i < 8; i++) a[i] = 8'($urandom_range(0, 255));
    in_valid = 1'b1;
    for (int n = 0; n < 10; n++) begin
      check("bp out_valid", 64'(out_valid), 1);
      check("bp in_ready", 64'(in_ready), 0);
      check("bp wr_pulse", 64'(wr_pulse), 0);
      check("bp c", 64'(c), {8'(expc[7]), 8'(expc[6]), 8'(expc[5]), 8'(expc[4]),
                              8'(expc[3]), 8'(expc[2]), 8'(expc[1]), 8'(expc[0])});
      step();
    end
    in_valid = 1'b0;
    check("bp no_pulse", 64'(wr_count - w0), 0);
    handshake("bp");

    // Reset after six butterflies
    ain = '{1, 0, 0, 0, 0, 0, 0, 0};
    set_tw(2, 1'b0);
    w0 = wr_count;
    drive_row();
    for (int n = 0; n < 6; n++) step();
    check("mid busy", 64'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid in_ready", 64'(in_ready), 1);
    check("mid out_valid", 64'(out_valid), 0);
    check("mid row_idx", 64'(row_idx), 0);
    check("mid busy_lo", 64'(busy), 0);
    exp_row = 0;
    step();
    rst_n = 1'b1;
    step();
    check("mid no_pulse", 64'(wr_count - w0), 0);
    drive_row();
    wait_done(lat);
    expc = '{1, 1, 1, 1, 1, 1, 1, 1};
    check_c("post_rst");
    handshake("post_rst");

    // 17 back-to-back random rows, row_idx wraps
    w0 = wr_count;
    for (int r = 0; r < 17; r++) begin
      for (int i = 0; i < 8; i++) ain[i] = $urandom_range(0, 255);
      set_tw(roots[$urandom_range(0, 3)], 1'b1);
      model();
      drive_row();
      wait_done(lat);
      check($sformatf("row%0d latency", r), 64'(lat), 12);
      check_c($sformatf("row%0d", r));
      handshake($sformatf("row%0d", r));
    end
    check("b2b pulses", 64'(wr_count - w0), 17);
    check("b2b row_idx", 64'(row_idx), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
